// File: rtl/ifm_out_fsm_if.sv
// Handshake bundle linking the S2MM output sequencer to its status/data FWFT FIFOs
// and to the S2MM status (rxs) and frame data (rxd) AXI-Stream channels.
interface ifm_out_fsm_if;
   logic [63:0] ctrl_fifo_rdata;
   logic        ctrl_fifo_empty;
   logic        ctrl_fifo_rden;
   logic [72:0] data_fifo_rdata;
   logic        data_fifo_empty;
   logic        data_fifo_rden;

   logic [31:0] rxs_tdata;
   logic [3:0]  rxs_tkeep;
   logic        rxs_tvalid;
   logic        rxs_tlast;
   logic        rxs_tready;

   logic [63:0] rxd_tdata;
   logic [7:0]  rxd_tkeep;
   logic        rxd_tvalid;
   logic        rxd_tlast;
   logic        rxd_tready;

   modport master (
      input  ctrl_fifo_rdata, ctrl_fifo_empty, data_fifo_rdata, data_fifo_empty,
      input  rxs_tready, rxd_tready,
      output ctrl_fifo_rden, data_fifo_rden,
      output rxs_tdata, rxs_tkeep, rxs_tvalid, rxs_tlast,
      output rxd_tdata, rxd_tkeep, rxd_tvalid, rxd_tlast
   );

   modport slave (
      output ctrl_fifo_rdata, ctrl_fifo_empty, data_fifo_rdata, data_fifo_empty,
      output rxs_tready, rxd_tready,
      input  ctrl_fifo_rden, data_fifo_rden,
      input  rxs_tdata, rxs_tkeep, rxs_tvalid, rxs_tlast,
      input  rxd_tdata, rxd_tkeep, rxd_tvalid, rxd_tlast
   );
endinterface

// File: rtl/ifm_out_fsm.sv
// S2MM output sequencer: pops one status word per frame, emits the six-word status
// packet, then streams the frame's data beats and checks the delivered byte count.
module ifm_out_fsm (
   input  logic                 s2mm_clk,
   input  logic                 s2mm_reset,
   ifm_out_fsm_if.master        bus,
   output logic                 len_err,
   output logic [31:0]          frame_cnt,
   output logic [3:0]           ifm_out_fsm_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_STS  = 2'd1,
      S_DATA = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state;
   logic [2:0]  wcnt;
   logic [15:0] bcnt;
   logic [47:0] sts_reg;
   logic [31:0] sts_word;
   logic        sts_fire;
   logic        dat_fire;
   logic        unused_rsvd;

   // Reserved status bits are carried by the FIFO but never forwarded.
   assign unused_rsvd = ^bus.ctrl_fifo_rdata[63:48];

   function automatic logic [3:0] keep_bytes(input logic [7:0] keep);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, keep[i]};
      end
      return n;
   endfunction

   // Every handshake output is forced low while reset is held, even before the
   // first reset edge has defined the state register.
   assign bus.ctrl_fifo_rden = ~s2mm_reset & (state == S_IDLE) & ~bus.ctrl_fifo_empty;

   assign bus.rxs_tvalid = ~s2mm_reset & (state == S_STS);
   assign bus.rxs_tkeep  = 4'hF;
   assign bus.rxs_tdata  = sts_word;
   assign bus.rxs_tlast  = bus.rxs_tvalid & (wcnt == 3'd5);

   assign bus.rxd_tvalid = ~s2mm_reset & (state == S_DATA) & ~bus.data_fifo_empty;
   assign bus.rxd_tdata  = bus.data_fifo_rdata[63:0];
   assign bus.rxd_tkeep  = bus.data_fifo_rdata[71:64];
   assign bus.rxd_tlast  = bus.rxd_tvalid & bus.data_fifo_rdata[72];

   assign bus.data_fifo_rden = bus.rxd_tvalid & bus.rxd_tready;

   assign sts_fire = bus.rxs_tvalid & bus.rxs_tready;
   assign dat_fire = bus.data_fifo_rden;

   assign ifm_out_fsm_dbg = {2'b00, state};

   // NOTE: every variable assigned in always_comb gets a default first so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      sts_word = 32'h0;
      case (wcnt)
         3'd0:    sts_word = {4'h5, 28'h0};
         3'd4:    sts_word = {sts_reg[47:32], 16'h0};
         3'd5:    sts_word = sts_reg[31:0];
         default: sts_word = 32'h0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge s2mm_clk) begin
      if (s2mm_reset) begin
         state     <= S_IDLE;
         wcnt      <= 3'd0;
         bcnt      <= 16'd0;
         len_err   <= 1'b0;
         frame_cnt <= 32'd0;
         sts_reg   <= 48'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!bus.ctrl_fifo_empty) begin
                  sts_reg <= bus.ctrl_fifo_rdata[47:0];
                  wcnt    <= 3'd0;
                  bcnt    <= 16'd0;
                  state   <= S_STS;
               end
            end
            S_STS: begin
               if (sts_fire) begin
                  wcnt <= wcnt + 3'd1;
                  if (wcnt == 3'd5) begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (dat_fire) begin
                  bcnt <= bcnt + {12'h000, keep_bytes(bus.data_fifo_rdata[71:64])};
                  if (bus.data_fifo_rdata[72]) begin
                     state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               // bcnt already includes the last beat accepted on the way in.
               if (bcnt != sts_reg[15:0]) begin
                  len_err <= 1'b1;
               end
               frame_cnt <= frame_cnt + 32'd1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ifm_out_fsm.sv
// Randomized self-checking bench for ifm_out_fsm: queue-based FIFO models feed the
// DUT, and a frame-level scoreboard predicts every status word and data beat.
module tb_ifm_out_fsm;

   logic        s2mm_clk   = 1'b0;
   logic        s2mm_reset = 1'b1;
   logic        len_err;
   logic [31:0] frame_cnt;
   logic [3:0]  fsm_dbg;

   ifm_out_fsm_if bus ();

   ifm_out_fsm dut (
      .s2mm_clk        (s2mm_clk),
      .s2mm_reset      (s2mm_reset),
      .bus             (bus),
      .len_err         (len_err),
      .frame_cnt       (frame_cnt),
      .ifm_out_fsm_dbg (fsm_dbg)
   );

   always #5 s2mm_clk = ~s2mm_clk;

   int n_checks = 0;
   int n_fail   = 0;

   // FIFO contents and scoreboard
   logic [63:0] cq[$];
   logic [72:0] dq[$];
   logic [72:0] bld[$];
   logic [32:0] exp_rxs[$];
   logic [72:0] exp_rxd[$];
   int          exp_frames  = 0;
   logic        exp_len_err = 1'b0;

   int ns = 0, nf = 0, n_cpop = 0, beats_popped = 0;
   int cyc = 0, last_tlast_cyc = -100;

   int rxs_mode = 0, rxd_mode = 0;
   bit toggle_ph = 1'b0, rnd_hide = 1'b0, hide_d = 1'b0;
   int stall_after = -1, stall_len = 0, stall_left = 0;
   bit s_pop_c = 1'b0, s_pop_d = 1'b0;
   bit prev_stall = 1'b0;
   logic [33:0] prev_rxs = '0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [5:0] out_flags();
      return {bus.rxs_tvalid, bus.rxs_tlast, bus.rxd_tvalid, bus.rxd_tlast,
              bus.ctrl_fifo_rden, bus.data_fifo_rden};
   endfunction

   // Builds one frame's beats into bld; returns the byte total modulo 2^16.
   task automatic make_beats(input int nb, input bit rand_keep, input logic [7:0] last_keep,
                             output logic [15:0] sum);
      int total = 0;
      bld.delete();
      for (int i = 0; i < nb; i++) begin
         logic [7:0]  k;
         logic [63:0] d;
         bit          lst;
         lst = (i == nb - 1);
         k   = rand_keep ? 8'($urandom_range(0, 255)) : 8'hFF;
         if (lst) k = last_keep;
         d   = {$urandom, $urandom};
         total += $countones(k);
         bld.push_back({lst, k, d});
      end
      sum = 16'(total);
   endtask

   task automatic push_frame(input logic [15:0] tpid, input logic [15:0] csum,
                             input logic [15:0] cnt, input logic [15:0] rsv,
                             input logic [15:0] sum);
      cq.push_back({rsv, tpid, csum, cnt});
      exp_rxs.push_back({1'b0, 4'h5, 28'h0});
      exp_rxs.push_back(33'h0);
      exp_rxs.push_back(33'h0);
      exp_rxs.push_back(33'h0);
      exp_rxs.push_back({1'b0, tpid, 16'h0});
      exp_rxs.push_back({1'b1, csum, cnt});
      foreach (bld[i]) begin
         dq.push_back(bld[i]);
         exp_rxd.push_back(bld[i]);
      end
      if (sum != cnt) exp_len_err = 1'b1;
      exp_frames++;
   endtask

   task automatic drive_fifo();
      logic [95:0] junk;
      junk = {$urandom, $urandom, $urandom};
      bus.ctrl_fifo_empty = (cq.size() == 0);
      bus.ctrl_fifo_rdata = (cq.size() != 0) ? cq[0] : junk[63:0];
      bus.data_fifo_empty = (dq.size() == 0) || hide_d;
      bus.data_fifo_rdata = (dq.size() != 0) ? dq[0] : junk[72:0];
   endtask

   task automatic drive_ready();
      toggle_ph = ~toggle_ph;
      case (rxs_mode)
         0:       bus.rxs_tready = 1'b1;
         1:       bus.rxs_tready = toggle_ph;
         default: bus.rxs_tready = 1'($urandom_range(0, 1));
      endcase
      case (rxd_mode)
         0:       bus.rxd_tready = 1'b1;
         1:       bus.rxd_tready = toggle_ph;
         default: bus.rxd_tready = 1'($urandom_range(0, 1));
      endcase
      hide_d = 1'b0;
      if (stall_left > 0) begin
         hide_d = 1'b1;
         stall_left--;
      end else if (rnd_hide && $urandom_range(0, 3) == 0) begin
         hide_d = 1'b1;
      end
   endtask

   task automatic monitor();
      logic sfire, dfire;
      cyc++;
      sfire   = bus.rxs_tvalid & bus.rxs_tready;
      dfire   = bus.rxd_tvalid & bus.rxd_tready;
      s_pop_c = bus.ctrl_fifo_rden;
      s_pop_d = bus.data_fifo_rden;
      check("data_rden", s_pop_d, dfire);
      if (bus.data_fifo_empty) check("rxd_valid_empty", bus.rxd_tvalid, 1'b0);
      if (prev_stall) check("rxs_stable", {bus.rxs_tvalid, bus.rxs_tlast, bus.rxs_tdata}, prev_rxs);
      if (s_pop_c) begin
         check("ctrl_pop_order", n_cpop, nf);
         check("ctrl_pop_gap", (cyc - last_tlast_cyc) >= 2, 1'b1);
         n_cpop++;
      end
      if (sfire) begin
         check("rxs_order", (ns / 6 == nf) && (n_cpop == nf + 1), 1'b1);
         check("rxs_tkeep", bus.rxs_tkeep, 4'hF);
         if (ns % 6 == 0) check("frame_gap", (cyc - last_tlast_cyc) >= 3, 1'b1);
         if (exp_rxs.size() == 0) check("rxs_extra", exp_rxs.size(), 1);
         else check("rxs_word", {bus.rxs_tlast, bus.rxs_tdata}, exp_rxs.pop_front());
         ns++;
      end
      if (dfire) begin
         check("rxd_order", ns == 6 * (nf + 1), 1'b1);
         if (exp_rxd.size() == 0) check("rxd_extra", exp_rxd.size(), 1);
         else check("rxd_beat", {bus.rxd_tlast, bus.rxd_tkeep, bus.rxd_tdata}, exp_rxd.pop_front());
         if (bus.rxd_tlast) begin
            nf++;
            last_tlast_cyc = cyc;
         end
      end
      prev_stall = bus.rxs_tvalid & ~bus.rxs_tready;
      prev_rxs   = {bus.rxs_tvalid, bus.rxs_tlast, bus.rxs_tdata};
   endtask

   // Sample on the falling edge, update FIFO models and inputs just after the rising edge.
   task automatic cycle();
      @(negedge s2mm_clk);
      monitor();
      @(posedge s2mm_clk);
      #1;
      if (s_pop_c && cq.size() != 0) void'(cq.pop_front());
      if (s_pop_d && dq.size() != 0) begin
         void'(dq.pop_front());
         beats_popped++;
         if (beats_popped == stall_after) stall_left = stall_len;
      end
      drive_ready();
      drive_fifo();
   endtask

   task automatic run_until_idle(input int budget);
      int idle = 0;
      int n    = 0;
      while (idle < 4) begin
         if (n >= budget) begin
            check("drain_timeout", exp_rxs.size() + exp_rxd.size() + cq.size(), 0);
            break;
         end
         cycle();
         n++;
         if (exp_rxs.size() == 0 && exp_rxd.size() == 0 && cq.size() == 0) idle++;
         else idle = 0;
      end
   endtask

   task automatic end_checks();
      check("frame_cnt", frame_cnt, exp_frames);
      check("len_err", len_err, exp_len_err);
      check("idle_state", fsm_dbg, 4'h0);
      check("ctrl_pops", n_cpop, nf);
      check("data_drained", dq.size(), 0);
   endtask

   task automatic good_frame(input int nb, input bit rand_keep);
      logic [15:0] sum;
      make_beats(nb, rand_keep, rand_keep ? 8'($urandom_range(0, 255)) : 8'hFF, sum);
      push_frame(16'($urandom), 16'($urandom), sum, 16'($urandom), sum);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] sum;
      int          c0, b0, n;

      drive_ready();
      drive_fifo();
      repeat (2) @(posedge s2mm_clk);
      @(negedge s2mm_clk);
      check("reset_outputs", out_flags(), 6'b0);
      @(posedge s2mm_clk);
      #1 s2mm_reset = 1'b0;
      @(negedge s2mm_clk);
      check("reset_frame_cnt", frame_cnt, 32'd0);
      check("reset_len_err", len_err, 1'b0);
      check("reset_state", fsm_dbg, 4'h0);
      check("reset_idle_outputs", out_flags(), 6'b0);
      @(posedge s2mm_clk);
      #1;

      // Reference frame: eight full beats, matching byte count.
      make_beats(8, 1'b0, 8'hFF, sum);
      push_frame(16'h1234, 16'hABCD, 16'h0040, 16'h0000, sum);
      drive_fifo();
      run_until_idle(200);
      end_checks();

      // Short last beat: 60 bytes against a count of 0x40; len_err then stays set.
      make_beats(8, 1'b0, 8'h0F, sum);
      check("short_frame_bytes", sum, 16'd60);
      push_frame(16'h1234, 16'hABCD, 16'h0040, 16'h0000, sum);
      drive_fifo();
      run_until_idle(200);
      end_checks();
      good_frame(5, 1'b1);
      drive_fifo();
      run_until_idle(200);
      end_checks();
      check("len_err_sticky", len_err, 1'b1);

      // Status channel back-pressure toggling every cycle.
      rxs_mode = 1;
      good_frame(4, 1'b0);
      drive_fifo();
      run_until_idle(300);
      end_checks();
      rxs_mode = 0;

      // Data FIFO runs dry for five cycles after the third beat.
      stall_after = beats_popped + 3;
      stall_len   = 5;
      good_frame(8, 1'b0);
      drive_fifo();
      run_until_idle(300);
      end_checks();
      stall_after = -1;

      // Two status words queued together.
      c0 = n_cpop;
      good_frame(3, 1'b1);
      good_frame(6, 1'b1);
      drive_fifo();
      run_until_idle(400);
      check("two_frame_pops", n_cpop - c0, 2);
      end_checks();

      // Randomized frames, back-pressure and FIFO underflow.
      for (int r = 0; r < 25; r++) begin
         rxs_mode = $urandom_range(0, 2);
         rxd_mode = $urandom_range(0, 2);
         rnd_hide = 1'($urandom_range(0, 1));
         for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
            make_beats($urandom_range(1, 8), 1'b1, 8'($urandom_range(0, 255)), sum);
            if ($urandom_range(0, 3) == 0)
               push_frame(16'($urandom), 16'($urandom), sum + 16'($urandom_range(1, 9)), 16'($urandom), sum);
            else
               push_frame(16'($urandom), 16'($urandom), sum, 16'($urandom), sum);
         end
         drive_fifo();
         run_until_idle(1500);
         end_checks();
      end
      rxs_mode = 0;
      rxd_mode = 0;
      rnd_hide = 1'b0;

      // Reset while the fourth of eight beats is being presented.
      b0 = beats_popped;
      good_frame(8, 1'b0);
      drive_fifo();
      n = 0;
      while (beats_popped < b0 + 3 && n < 200) begin
         cycle();
         n++;
      end
      check("reset_reach_beat4", beats_popped - b0, 3);
      s2mm_reset = 1'b1;
      @(negedge s2mm_clk);
      check("reset_mid_outputs", out_flags(), 6'b0);
      @(posedge s2mm_clk);
      #1 s2mm_reset = 1'b0;
      @(negedge s2mm_clk);
      check("reset_mid_state", fsm_dbg, 4'h0);
      check("reset_mid_frame_cnt", frame_cnt, 32'd0);
      check("reset_mid_len_err", len_err, 1'b0);
      check("reset_mid_idle_outputs", out_flags(), 6'b0);
      dq.delete();
      exp_rxd.delete();
      exp_rxs.delete();
      ns = 0;
      nf = 0;
      n_cpop = 0;
      exp_frames = 0;
      exp_len_err = 1'b0;
      last_tlast_cyc = cyc - 100;
      prev_stall = 1'b0;
      @(posedge s2mm_clk);
      #1;
      good_frame(4, 1'b1);
      drive_fifo();
      run_until_idle(200);
      end_checks();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
